// File: rtl/majority_sample_collector.sv
// majority_sample_collector: oversamples a synchronized serial bit at a strobe rate
// and hands a NSAMP-wide window to the majority voter over valid/ready.
module majority_sample_collector #(
    parameter int DIV   = 4,
    parameter int NSAMP = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_din,
    output logic [NSAMP-1:0] o_win_out,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic             o_busy,
    output logic             o_overrun
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VALID} state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NSAMP-1:0] r_win;
    logic             r_busy;
    logic             r_valid;
    logic             r_overrun;

    logic w_din_s;
    logic w_strobe;
    logic w_last;
    logic w_go;

    assign w_din_s  = r_sync[1];
    assign w_strobe = (r_cnt == CW'(DIV - 1));
    assign w_last   = (r_idx == IW'(NSAMP - 1));
    // a new window may start from IDLE, or back-to-back on the edge the old one is consumed
    assign w_go     = i_start && ((r_state == IDLE) || ((r_state == VALID) && i_win_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sync    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_win     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (w_go) begin
                r_state <= COLLECT;
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
                r_win   <= '0;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    COLLECT: begin
                        r_cnt <= w_strobe ? '0 : r_cnt + 1'b1;
                        if (w_strobe) begin
                            r_win[r_idx] <= w_din_s;
                            r_idx        <= w_last ? '0 : r_idx + 1'b1;
                            if (w_last) begin
                                r_state <= VALID;
                                r_busy  <= 1'b0;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    VALID: begin
                        if (i_win_ready) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end else if (i_start) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    IDLE: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_win_out   = r_win;
    assign o_win_valid = r_valid;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_majority_sample_collector.sv
// tb_majority_sample_collector: directed checks of window timing, content,
// backpressure/overrun, back-to-back windows and async reset.
module tb_majority_sample_collector;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       win_ready = 1'b0;
    logic [6:0] win_out;
    logic       win_valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    majority_sample_collector #(.DIV(4), .NSAMP(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_din       (din),
        .o_win_out   (win_out),
        .o_win_valid (win_valid),
        .i_win_ready (win_ready),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_win"}, 32'(win_out), 32'h0);
        check({tag, "_valid"}, 32'(win_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ovr"}, 32'(overrun), 32'h0);
    endtask

    // async reset asserted between edges, checked before any clock edge
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_state(tag);
        tick();
        rst_n = 1'b1;
    endtask

    logic [6:0] pat = 7'b1001101;
    logic [6:0] held;
    int bad;

    initial begin
        #1 check_reset_state("por");
        tick();
        rst_n = 1'b1;

        // window of steady ones, timing of busy/valid
        din = 1'b1;
        win_ready = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy_e0", 32'(busy), 32'h1);
        bad = 0;
        for (int n = 1; n <= 27; n++) begin
            tick();
            if (busy !== 1'b1 || win_valid !== 1'b0) bad++;
        end
        check("t2_busy_span", 32'(bad), 32'h0);
        tick();
        check("t2_valid_e28", 32'(win_valid), 32'h1);
        check("t2_busy_e28", 32'(busy), 32'h0);
        check("t2_win", 32'(win_out), 32'h7F);
        tick();
        check("t2_valid_e29", 32'(win_valid), 32'h0);

        // directed bit pattern, bit0 = first sample
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 7; n++) begin
            din = pat[n];
            repeat (4) tick();
        end
        check("t3_valid", 32'(win_valid), 32'h1);
        check("t3_win", 32'(win_out), 32'h4D);
        tick();

        // backpressure with a refused start
        din = 1'b0;
        win_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (28) tick();
        check("t4_valid", 32'(win_valid), 32'h1);
        check("t4_ovr_pre", 32'(overrun), 32'h0);
        held = win_out;
        check("t4_win", 32'(held), 32'h0);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            start = (n == 4);
            tick();
            if (win_valid !== 1'b1 || win_out !== held || busy !== 1'b0) bad++;
        end
        start = 1'b0;
        check("t4_stable", 32'(bad), 32'h0);
        check("t4_ovr", 32'(overrun), 32'h1);
        win_ready = 1'b1;
        tick();
        check("t4_valid_done", 32'(win_valid), 32'h0);
        check("t4_busy_idle", 32'(busy), 32'h0);
        check("t4_ovr_sticky", 32'(overrun), 32'h1);

        // reset clears the sticky overrun
        pulse_reset("t1_rst");

        // back-to-back windows
        din = 1'b1;
        win_ready = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (28) tick();
        check("t5_valid1", 32'(win_valid), 32'h1);
        check("t5_win1", 32'(win_out), 32'h7F);
        din = 1'b0;
        start = 1'b1;
        win_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy", 32'(busy), 32'h1);
        check("t5_valid_low", 32'(win_valid), 32'h0);
        check("t5_ovr", 32'(overrun), 32'h0);
        check("t5_win_clr", 32'(win_out), 32'h0);
        repeat (27) tick();
        check("t5_valid_e27", 32'(win_valid), 32'h0);
        tick();
        check("t5_valid2", 32'(win_valid), 32'h1);
        check("t5_win2", 32'(win_out), 32'h0);
        tick();

        // reset in the middle of a window
        din = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (17) tick();
        check("t6_partial", 32'(win_out), 32'h0F);
        pulse_reset("t6_rst");
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (win_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("t6_quiet", 32'(bad), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        check("t6_valid_e27", 32'(win_valid), 32'h0);
        tick();
        check("t6_valid_e28", 32'(win_valid), 32'h1);
        check("t6_win", 32'(win_out), 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
